lcd_cmd_scheduler: RTL and testbench
====================================

// Module: lcd_cmd_scheduler
// PURPOSE
//  Command scheduler in front of the 8x8 image display controller (cmd/cmd_valid/busy/done).
//  Buffers host commands in a FIFO and issues each one as a 1-cycle cmd_valid pulse when the
//  controller is idle. Rejects illegal codes. Treats Write (cmd 0) as the terminal command:
//  after issuing it, waits for the controller's done and then reports completion.
// PARAMETERS
//  DEPTH     8   FIFO entries (power of 2, >=2)
//  MAX_CMD   11  highest legal opcode (0 Write, 1-4 Shift U/D/L/R, 5 Max, 6 Min, 7 Avg,
//                8 CCW, 9 CW, 10 MirrorX, 11 MirrorY)
//  GUARD     1   cycles after an issue during which busy is ignored (controller busy latency)
// PORTS
//  clk         in   1   single clock; all state updates on the rising edge
//  reset       in   1   asynchronous, active-high reset
//  host_cmd    in   4   opcode from host
//  host_valid  in   1   host offers host_cmd this cycle
//  host_ready  out  1   comb: FIFO not full and wr_lock==0; push when host_valid&host_ready
//  cmd         out  4   opcode to controller (registered)
//  cmd_valid   out  1   1-cycle issue strobe to controller (registered)
//  busy        in   1   controller busy (high during image load and while executing)
//  done        in   1   controller finished Write-back of the image
//  q_count     out  log2(DEPTH)+1  FIFO occupancy
//  issued_cnt  out  8   commands issued since reset, saturates at 255
//  err_illegal out  1   1-cycle pulse: illegal opcode offered while host_ready==1 (dropped)
//  sched_done  out  1   1-cycle pulse after done is seen following a Write issue
// BEHAVIOUR
//  Reset values: cmd=0, cmd_valid=0, q_count=0, issued_cnt=0, err_illegal=0, sched_done=0,
//   wr_lock=0, state=INIT. FIFO pointers cleared. host_ready is therefore 1 during reset.
//  Push: accepted when host_valid & host_ready & host_cmd<=MAX_CMD.
//   An illegal code with host_valid & host_ready pulses err_illegal the next cycle and is not
//   stored. With host_ready==0 nothing is checked.
//   Accepting opcode 0 sets wr_lock. No further pushes are accepted until sched_done.
//  Pop: happens only in the IDLE->ISSUE transition. Simultaneous push and pop keeps q_count.
//   A push to a full FIFO is impossible because host_ready==0.
//   A pop of an empty FIFO never occurs, because IDLE requires q_count!=0.
//  FSM:
//   INIT   : wait for busy==0 (controller image load) -> IDLE. Pushes are allowed here.
//   IDLE   : if q_count!=0 and busy==0 -> ISSUE. Otherwise stay.
//   ISSUE  : one cycle. cmd<=head, cmd_valid<=1, pop, issued_cnt++ (sat), gcnt<=GUARD.
//            -> GUARD. cmd_valid drops to 0 the next cycle; cmd holds its value.
//   GUARD  : gcnt-- each cycle, busy ignored. At 0: -> DRAIN if the issued cmd==0,
//            else -> WAIT.
//   WAIT   : stay while busy==1. When busy==0 -> IDLE. Back-to-back issue gap is at least
//            GUARD+2 cycles.
//   DRAIN  : wait for done==1, then sched_done<=1 (1 cycle), wr_lock<=0 -> INIT.
//            Commands left in the FIFO after a Write are impossible because of wr_lock.
//  Latency: a push into an empty FIFO with the controller idle gives cmd_valid 2 cycles
//   after the push edge (FIFO write, IDLE decision, ISSUE register).
//  done seen outside DRAIN is ignored. busy rising in IDLE blocks issue until it falls.
//  Reset mid-operation: everything returns to the reset values immediately (asynchronous).
//   The FIFO contents are discarded, and any cmd_valid in flight is cleared.
// TESTING
//  1 Reset, busy=1 for 10 cycles then 0; push 3 (Left) at cycle 2 -> cmd_valid with cmd=3 exactly
//    2 cycles after busy falls, never while busy=1; issued_cnt=1.
//  2 Push 1,2,5,9 back-to-back with the controller holding busy 4 cycles per cmd -> four
//    cmd_valid pulses in order 1,2,5,9; each is issued only after busy is low; q_count 4->0.
//  3 Push 9 entries with DEPTH=8 while busy=1 -> host_ready=0 after 8 pushes; the 9th is held by
//    the host and accepted on the first pop; no entry is lost or duplicated.
//  4 Push 12, then 15 -> err_illegal pulses twice; q_count unchanged; no issue.
//  5 Push 7 then 0 -> host_ready=0 after 0 is accepted; Write is issued; DRAIN; done=1 at cycle N
//    -> sched_done at N+1; host_ready=1 again.
//  6 Assert reset with 3 entries queued and in WAIT -> q_count=0, cmd_valid=0, state=INIT
//    immediately; after release, nothing is issued until new pushes arrive.

Source files
------------

// File: rtl/lcd_cmd_scheduler.sv
// Command scheduler in front of the 8x8 image display controller: buffers host opcodes in a FIFO
// and issues them one at a time as cmd_valid strobes while the controller is idle.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// INIT   | waiting for the controller's image load (busy) to finish
// IDLE   | controller idle, waiting for a queued command
// ISSUE  | drive cmd/cmd_valid from the FIFO head, pop, count the issue
// GUARD  | ignore busy while the controller raises it after an issue
// WAIT   | controller executing, wait for busy to fall
// DRAIN  | Write issued, wait for done then report sched_done
module lcd_cmd_scheduler #(
    parameter int DEPTH   = 8,
    parameter int MAX_CMD = 11,
    parameter int GUARD   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [7:0]               issued_cnt,
    output logic                     err_illegal,
    output logic                     sched_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_lock;
    logic [7:0]      gcnt;
    logic            full;
    logic            offer;
    logic            legal;
    logic            push;
    logic            pop;

    assign full       = (q_count == (AW+1)'(DEPTH));
    assign host_ready = !full && !wr_lock;
    assign offer      = host_valid && host_ready;
    assign legal      = (host_cmd <= 4'(MAX_CMD));
    assign push       = offer && legal;
    assign pop        = (state == S_ISSUE);

    // Storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_count     <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= offer && !legal;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            cmd        <= 4'd0;
            cmd_valid  <= 1'b0;
            issued_cnt <= 8'd0;
            sched_done <= 1'b0;
            wr_lock    <= 1'b0;
            gcnt       <= 8'd0;
        end else begin
            cmd_valid  <= 1'b0;
            sched_done <= 1'b0;
            // Write is terminal: lock out the host until its completion is reported.
            if (push && host_cmd == 4'd0) begin
                wr_lock <= 1'b1;
            end
            case (state)
                S_INIT: begin
                    if (!busy) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (q_count != '0 && !busy) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd       <= mem[rd_ptr];
                    cmd_valid <= 1'b1;
                    if (issued_cnt != 8'hFF) begin
                        issued_cnt <= issued_cnt + 8'd1;
                    end
                    gcnt  <= 8'(GUARD);
                    state <= S_GUARD;
                end
                S_GUARD: begin
                    if (gcnt == 8'd0) begin
                        state <= (cmd == 4'd0) ? S_DRAIN : S_WAIT;
                    end else begin
                        gcnt <= gcnt - 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!busy) begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (done) begin
                        sched_done <= 1'b1;
                        wr_lock    <= 1'b0;
                        state      <= S_INIT;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler: scoreboard of accepted opcodes checked against issues,
// plus a simple controller model that raises busy for a programmable time after each issue.
module tb_lcd_cmd_scheduler;

    localparam int DEPTH   = 8;
    localparam int MAX_CMD = 11;
    localparam int GUARD   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       busy_force;
    logic       model_busy;
    logic       done;
    logic [3:0] q_count;
    logic [7:0] issued_cnt;
    logic       err_illegal;
    logic       sched_done;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_issued = 0;
    int         model_hold = 4;
    int         mcnt;
    logic [3:0] sb [$];

    logic [1:0] bh;
    int         cyc;
    int         last_cyc;
    bit         have_last;
    logic [3:0] exp_cmd;

    assign busy = busy_force | model_busy;

    lcd_cmd_scheduler #(.DEPTH(DEPTH), .MAX_CMD(MAX_CMD), .GUARD(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .q_count    (q_count),
        .issued_cnt (issued_cnt),
        .err_illegal(err_illegal),
        .sched_done (sched_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model: busy for model_hold cycles after every cmd_valid.
    initial begin
        model_busy = 1'b0;
        mcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_busy = 1'b0;
                mcnt = 0;
            end else if (model_busy) begin
                if (mcnt == 0) model_busy = 1'b0;
                else mcnt--;
            end else if (cmd_valid) begin
                model_busy = 1'b1;
                mcnt = model_hold - 1;
            end
        end
    end

    // Issue monitor: pops the scoreboard on every cmd_valid.
    initial begin
        bh = 2'b00;
        cyc = 0;
        last_cyc = 0;
        have_last = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            bh = {bh[0], busy};
            @(negedge clk);
            if (reset) begin
                have_last = 1'b0;
            end else if (cmd_valid) begin
                n_issued++;
                check("busy_low_at_decision", 32'(bh[1]), 32'd0);
                if (sb.size() == 0) begin
                    check("issue_without_accepted_cmd", 32'(sb.size()), 32'd1);
                end else begin
                    exp_cmd = sb.pop_front();
                    check("issue_order", 32'(cmd), 32'(exp_cmd));
                end
                if (have_last) check("issue_gap", 32'((cyc - last_cyc) >= GUARD + 2), 32'd1);
                last_cyc = cyc;
                have_last = 1'b1;
            end
        end
    end

    task automatic push_op(input logic [3:0] op);
        int waited = 0;
        host_cmd   = op;
        host_valid = 1'b1;
        while (!host_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("push_accept", 32'(host_ready), 32'd1);
        if (host_ready) begin
            if (op <= MAX_CMD) sb.push_back(op);
            @(negedge clk);
            host_valid = 1'b0;
            check("err_illegal", 32'(err_illegal), 32'(op > MAX_CMD));
        end else begin
            host_valid = 1'b0;
        end
    endtask

    task automatic wait_quiet(input string tag);
        int k = 0;
        int calm = 0;
        while (calm < 4 && k < 600) begin
            @(negedge clk);
            k++;
            if (q_count == 4'd0 && !busy && !cmd_valid) calm++;
            else calm = 0;
        end
        check(tag, 32'(calm >= 4), 32'd1);
    endtask

    task automatic wait_issued(input string tag, input int target);
        int k = 0;
        while (n_issued < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(n_issued), 32'(target));
    endtask

    initial begin
        reset      = 1'b1;
        host_cmd   = 4'd0;
        host_valid = 1'b0;
        busy_force = 1'b1;
        done       = 1'b0;
        #12;
        check("rst_cmd",         32'(cmd),         32'd0);
        check("rst_cmd_valid",   32'(cmd_valid),   32'd0);
        check("rst_q_count",     32'(q_count),     32'd0);
        check("rst_issued_cnt",  32'(issued_cnt),  32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        check("rst_sched_done",  32'(sched_done),  32'd0);
        check("rst_host_ready",  32'(host_ready),  32'd1);

        // 1: single Left while controller loads; issue 2 edges after busy is first seen low
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push_op(4'd3);
        check("t1_q_count", 32'(q_count), 32'd1);
        repeat (6) @(negedge clk);
        check("t1_no_issue_while_busy", 32'(n_issued), 32'd0);
        @(negedge clk);
        busy_force = 1'b0;
        @(negedge clk);
        check("t1_valid_edge1", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_edge2", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_edge3", 32'(cmd_valid), 32'd1);
        check("t1_cmd", 32'(cmd), 32'd3);
        wait_quiet("t1_quiet");
        check("t1_issued_cnt", 32'(issued_cnt), 32'd1);

        // 2: four queued commands issued in order
        model_hold = 4;
        busy_force = 1'b1;
        push_op(4'd1);
        push_op(4'd2);
        push_op(4'd5);
        push_op(4'd9);
        check("t2_q_count_full4", 32'(q_count), 32'd4);
        busy_force = 1'b0;
        wait_quiet("t2_quiet");
        check("t2_q_count_empty", 32'(q_count), 32'd0);
        check("t2_issued_cnt", 32'(issued_cnt), 32'd5);
        check("t2_n_issued", 32'(n_issued), 32'd5);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: fill FIFO, ninth entry held until the first pop
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_op(4'(i + 1));
        check("t3_host_ready_full", 32'(host_ready), 32'd0);
        check("t3_q_count_full", 32'(q_count), 32'(DEPTH));
        fork
            push_op(4'd10);
            begin
                repeat (3) @(negedge clk);
                busy_force = 1'b0;
            end
        join
        wait_quiet("t3_quiet");
        check("t3_issued_cnt", 32'(issued_cnt), 32'd14);
        check("t3_n_issued", 32'(n_issued), 32'd14);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 4: illegal opcodes dropped; done outside DRAIN ignored
        push_op(4'd12);
        push_op(4'd15);
        @(negedge clk);
        check("t4_err_pulse_ends", 32'(err_illegal), 32'd0);
        check("t4_q_count", 32'(q_count), 32'd0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("t4_done_ignored", 32'(sched_done), 32'd0);
        repeat (5) @(negedge clk);
        check("t4_no_issue", 32'(n_issued), 32'd14);
        check("t4_issued_cnt", 32'(issued_cnt), 32'd14);

        // 5: Avg then Write; host locked out until sched_done
        push_op(4'd7);
        push_op(4'd0);
        check("t5_locked", 32'(host_ready), 32'd0);
        wait_issued("t5_write_issued", 16);
        repeat (4) @(negedge clk);
        check("t5_no_early_done", 32'(sched_done), 32'd0);
        check("t5_still_locked", 32'(host_ready), 32'd0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("t5_sched_done", 32'(sched_done), 32'd1);
        check("t5_unlocked", 32'(host_ready), 32'd1);
        @(negedge clk);
        check("t5_sched_done_pulse", 32'(sched_done), 32'd0);
        wait_quiet("t5_quiet");

        // 6: asynchronous reset with entries queued while in WAIT
        model_hold = 30;
        push_op(4'd4);
        push_op(4'd5);
        push_op(4'd6);
        push_op(4'd8);
        wait_issued("t6_first_issued", 17);
        repeat (4) @(negedge clk);
        check("t6_q_count_before", 32'(q_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_q_count_reset", 32'(q_count), 32'd0);
        check("t6_cmd_valid_reset", 32'(cmd_valid), 32'd0);
        check("t6_issued_cnt_reset", 32'(issued_cnt), 32'd0);
        check("t6_host_ready_reset", 32'(host_ready), 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_hold = 4;
        repeat (20) @(negedge clk);
        check("t6_nothing_after_reset", 32'(n_issued), 32'd17);
        check("t6_issued_cnt_idle", 32'(issued_cnt), 32'd0);
        push_op(4'd6);
        wait_quiet("t6_quiet");
        check("t6_issued_cnt_new", 32'(issued_cnt), 32'd1);
        check("t6_n_issued_new", 32'(n_issued), 32'd18);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
